cp_remover: RTL and testbench



---
 rtl/axis_skid2.sv | 68 ++++++
 rtl/cp_remover.sv | 99 +++++++++
 tb/tb_cp_remover.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_skid2.sv
// rtl/axis_skid2.sv - two-entry stream skid buffer carrying data plus a last flag
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   s_tvalid/s_tready     : write side handshake (s_tready = not full)
//   s_tdata/s_tlast       : entry written on push
//   m_tvalid/m_tready     : read side handshake (m_tvalid = not empty)
//   m_tdata/m_tlast       : head entry, held stable until popped
module axis_skid2 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast
);

    logic [DATA_W-1:0] mem_data [2];
    logic [1:0]        mem_last;
    logic              head;
    logic              tail;
    logic [1:0]        count;
    logic              push;
    logic              pop;

    // Ready depends only on the registered count, so there is no
    // combinational path from m_tready back to s_tready.
    assign s_tready = (count != 2'd2);
    assign m_tvalid = (count != 2'd0);
    assign m_tdata  = mem_data[head];
    assign m_tlast  = mem_last[head];

    assign push = s_tvalid && s_tready;
    assign pop  = m_tvalid && m_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Entries are cleared so the idle outputs read as zero.
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_last    <= '0;
            head        <= 1'b0;
            tail        <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                mem_data[tail] <= s_tdata;
                mem_last[tail] <= s_tlast;
                tail           <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cp_remover.sv
// rtl/cp_remover.sv - strips the cyclic prefix from each OFDM symbol of a sample stream
//
// Ports:
//   s00_axis_aclk, s00_axis_aresetn : clock, asynchronous active-low reset
//   s00_axis_*                      : input samples, tlast closes a symbol (CP included)
//   m00_axis_*                      : body samples only, tlast on last body sample
//   sync_err                        : sticky, set when input tlast arrives early
module cp_remover #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int FFT_LEN            = 64,
    parameter int CP_LEN             = 16
) (
    input  logic                            s00_axis_aclk,
    input  logic                            s00_axis_aresetn,
    input  logic                            s00_axis_tvalid,
    output logic                            s00_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                            s00_axis_tlast,
    output logic                            m00_axis_tvalid,
    input  logic                            m00_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                            m00_axis_tlast,
    output logic                            sync_err
);

    localparam logic [0:0] S_CP   = 1'b0;
    localparam logic [0:0] S_BODY = 1'b1;

    // The same counter walks both the prefix and the body, so it is sized
    // for whichever is longer in case a prefix exceeds the FFT length.
    localparam int CNT_N = (FFT_LEN > CP_LEN) ? FFT_LEN : CP_LEN;
    localparam int CNT_W = $clog2(CNT_N);

    localparam logic [CNT_W-1:0] CP_LAST   = CNT_W'(CP_LEN - 1);
    localparam logic [CNT_W-1:0] BODY_LAST = CNT_W'(FFT_LEN - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] samp_cnt;
    logic             accept;
    logic             body_last;
    logic             push;
    logic             push_last;
    logic             skid_ready;

    // Byte strobes carry no information for complex samples.
    logic unused_tstrb;
    assign unused_tstrb   = &{1'b0, s00_axis_tstrb};
    assign m00_axis_tstrb = '1;

    always_comb begin
        s00_axis_tready = (state == S_CP) ? 1'b1 : skid_ready;
        accept          = s00_axis_tvalid && s00_axis_tready;
        body_last       = (state == S_BODY) && (samp_cnt == BODY_LAST);
        push            = accept && (state == S_BODY);
        // An early tlast still closes the partial symbol downstream.
        push_last       = body_last || s00_axis_tlast;
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state    <= S_CP;
            samp_cnt <= '0;
            sync_err <= 1'b0;
        end else if (accept) begin
            if (body_last) begin
                // Symbol complete; a missing input tlast here is tolerated.
                state    <= S_CP;
                samp_cnt <= '0;
            end else if (s00_axis_tlast) begin
                sync_err <= 1'b1;
                state    <= S_CP;
                samp_cnt <= '0;
            end else if ((state == S_CP) && (samp_cnt == CP_LAST)) begin
                state    <= S_BODY;
                samp_cnt <= '0;
            end else begin
                samp_cnt <= samp_cnt + 1'b1;
            end
        end
    end

    axis_skid2 #(
        .DATA_W (C_AXIS_TDATA_WIDTH)
    ) u_skid (
        .clk      (s00_axis_aclk),
        .rst_n    (s00_axis_aresetn),
        .s_tvalid (push),
        .s_tready (skid_ready),
        .s_tdata  (s00_axis_tdata),
        .s_tlast  (push_last),
        .m_tvalid (m00_axis_tvalid),
        .m_tready (m00_axis_tready),
        .m_tdata  (m00_axis_tdata),
        .m_tlast  (m00_axis_tlast)
    );

endmodule

// File: tb/tb_cp_remover.sv
// tb/tb_cp_remover.sv - randomized self-checking bench for cp_remover
module tb_cp_remover;

    localparam int FFT = 8;
    localparam int CP  = 2;
    localparam int SYM = FFT + CP;

    logic        clk;
    logic        rst_n;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;
    logic        s_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        m_tlast;
    logic        sync_err;

    cp_remover #(
        .C_AXIS_TDATA_WIDTH (32),
        .FFT_LEN            (FFT),
        .CP_LEN             (CP)
    ) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tvalid  (s_tvalid),
        .s00_axis_tready  (s_tready),
        .s00_axis_tdata   (s_tdata),
        .s00_axis_tstrb   (s_tstrb),
        .s00_axis_tlast   (s_tlast),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tready  (m_tready),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tstrb   (m_tstrb),
        .m00_axis_tlast   (m_tlast),
        .sync_err         (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: position of the next sample within its symbol.
    int          pos;
    bit          exp_err;
    logic [31:0] exp_d[$];
    logic        exp_l[$];
    logic [31:0] act_d[$];
    logic        act_l[$];
    int          in_last_k[$];
    int          rule_err;
    int          stab_err;
    int          timeouts;
    bit          saw_busy;

    function automatic bit is_last(input int k);
        foreach (in_last_k[i]) if (in_last_k[i] == k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_accept(input int k, input bit tl);
        if (pos >= CP) begin
            exp_d.push_back(k);
            exp_l.push_back((pos == SYM - 1) || tl);
        end
        if (tl && pos != SYM - 1) begin
            exp_err = 1'b1;
            pos     = 0;
        end else begin
            pos = (pos + 1) % SYM;
        end
    endtask

    task automatic clear_model();
        pos = 0;
        exp_err = 1'b0;
        exp_d.delete(); exp_l.delete();
        act_d.delete(); act_l.delete();
    endtask

    task automatic apply_reset();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        clear_model();
    endtask

    // Drives samples k0..k0+n-1 and collects outputs; per-cycle protocol
    // rules are tallied into rule_err/stab_err for the caller to judge.
    task automatic run(input int k0, input int n, input int vpct, input int rpct,
                       input int st_lo, input int st_hi, input bit drain);
        int k = k0;
        int cyc = 0;
        int tail = 0;
        int occ;
        bit in_body;
        bit acc;
        bit done = 1'b0;
        bit prev_stall = 1'b0;
        logic [31:0] prev_d = '0;
        logic prev_l = 1'b0;
        rule_err = 0; stab_err = 0; timeouts = 0; saw_busy = 1'b0;
        while (cyc < 20000) begin
            if (k == k0 + n) begin
                if (!drain) begin done = 1'b1; break; end
                if (act_d.size() >= exp_d.size()) tail++;
                if (tail > 3) begin done = 1'b1; break; end
            end
            if (k < k0 + n) begin
                if (!s_tvalid) s_tvalid = (int'($urandom_range(99)) < vpct);
            end else begin
                s_tvalid = 1'b0;
            end
            s_tdata = k;
            s_tlast = is_last(k);
            if (cyc >= st_lo && cyc <= st_hi) m_tready = 1'b0;
            else if (k == k0 + n)             m_tready = 1'b1;
            else                              m_tready = (int'($urandom_range(99)) < rpct);
            @(negedge clk);
            occ     = exp_d.size() - act_d.size();
            in_body = (pos >= CP);
            if (s_tready !== !(in_body && occ == 2)) rule_err++;
            if (m_tvalid !== (occ != 0)) rule_err++;
            if (prev_stall && (m_tdata !== prev_d || m_tlast !== prev_l)) stab_err++;
            if (!s_tready) saw_busy = 1'b1;
            if (m_tvalid && m_tready) begin
                act_d.push_back(m_tdata);
                act_l.push_back(m_tlast);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d = m_tdata;
            prev_l = m_tlast;
            acc = s_tvalid && s_tready;
            if (acc) model_accept(k, s_tlast);
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                s_tvalid = 1'b0;
                k++;
            end
        end
        if (!done) timeouts = 1;
        s_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (m_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", m_tvalid); else n_pass++;
        n_checks++; if (m_tlast !== 1'b0) $display("FAIL reset_tlast got %b want 0", m_tlast); else n_pass++;
        n_checks++; if (m_tdata !== 32'h0) $display("FAIL reset_tdata got %h want 0", m_tdata); else n_pass++;
        n_checks++; if (sync_err !== 1'b0) $display("FAIL reset_sync_err got %b want 0", sync_err); else n_pass++;
        n_checks++; if (s_tready !== 1'b1) $display("FAIL reset_tready got %b want 1", s_tready); else n_pass++;
        n_checks++; if (m_tstrb !== 4'hF) $display("FAIL reset_tstrb got %h want f", m_tstrb); else n_pass++;
    endtask

    task automatic test_continuous();
        int nl = 0;
        apply_reset();
        in_last_k = '{9, 19, 29};
        run(0, 30, 100, 100, -1, -1, 1'b1);
        n_checks++; if (timeouts !== 0) $display("FAIL cont_timeout got %0d want 0", timeouts); else n_pass++;
        n_checks++; if (act_d.size() !== 24) $display("FAIL cont_count got %0d want 24", act_d.size()); else n_pass++;
        n_checks++; if (exp_d.size() !== 24) $display("FAIL cont_model_count got %0d want 24", exp_d.size()); else n_pass++;
        for (int i = 0; i < act_d.size() && i < exp_d.size(); i++) begin
            n_checks++;
            if (act_d[i] !== exp_d[i] || act_l[i] !== exp_l[i])
                $display("FAIL cont_out[%0d] got %h/%b want %h/%b", i, act_d[i], act_l[i], exp_d[i], exp_l[i]);
            else n_pass++;
            if (act_l[i]) nl++;
        end
        n_checks++; if (act_d.size() > 0 && act_d[0] !== 32'd2) $display("FAIL cont_first got %h want 2", act_d[0]); else n_pass++;
        n_checks++; if (nl !== 3) $display("FAIL cont_tlast_count got %0d want 3", nl); else n_pass++;
        n_checks++; if (rule_err !== 0) $display("FAIL cont_handshake got %0d errs want 0", rule_err); else n_pass++;
        n_checks++; if (sync_err !== 1'b0) $display("FAIL cont_sync_err got %b want 0", sync_err); else n_pass++;
    endtask

    task automatic test_stall();
        apply_reset();
        in_last_k = '{9, 19, 29};
        run(0, 30, 100, 100, 5, 12, 1'b1);
        n_checks++; if (timeouts !== 0) $display("FAIL stall_timeout got %0d want 0", timeouts); else n_pass++;
        n_checks++; if (act_d.size() !== 24) $display("FAIL stall_count got %0d want 24", act_d.size()); else n_pass++;
        for (int i = 0; i < act_d.size() && i < exp_d.size(); i++) begin
            n_checks++;
            if (act_d[i] !== exp_d[i] || act_l[i] !== exp_l[i])
                $display("FAIL stall_out[%0d] got %h/%b want %h/%b", i, act_d[i], act_l[i], exp_d[i], exp_l[i]);
            else n_pass++;
        end
        n_checks++; if (saw_busy !== 1'b1) $display("FAIL stall_tready_drop got %b want 1", saw_busy); else n_pass++;
        n_checks++; if (rule_err !== 0) $display("FAIL stall_handshake got %0d errs want 0", rule_err); else n_pass++;
        n_checks++; if (stab_err !== 0) $display("FAIL stall_stability got %0d errs want 0", stab_err); else n_pass++;
    endtask

    task automatic test_random();
        apply_reset();
        in_last_k.delete();
        for (int s = 0; s < 100; s++) in_last_k.push_back(s * SYM + SYM - 1);
        run(0, 100 * SYM, 50, 50, -1, -1, 1'b1);
        n_checks++; if (timeouts !== 0) $display("FAIL rand_timeout got %0d want 0", timeouts); else n_pass++;
        n_checks++; if (act_d.size() !== 100 * FFT) $display("FAIL rand_count got %0d want %0d", act_d.size(), 100 * FFT); else n_pass++;
        for (int i = 0; i < act_d.size() && i < exp_d.size(); i++) begin
            n_checks++;
            if (act_d[i] !== exp_d[i] || act_l[i] !== exp_l[i])
                $display("FAIL rand_out[%0d] got %h/%b want %h/%b", i, act_d[i], act_l[i], exp_d[i], exp_l[i]);
            else n_pass++;
        end
        n_checks++; if (rule_err !== 0) $display("FAIL rand_handshake got %0d errs want 0", rule_err); else n_pass++;
        n_checks++; if (stab_err !== 0) $display("FAIL rand_stability got %0d errs want 0", stab_err); else n_pass++;
        n_checks++; if (sync_err !== 1'b0) $display("FAIL rand_sync_err got %b want 0", sync_err); else n_pass++;
    endtask

    task automatic test_early_tlast();
        apply_reset();
        in_last_k = '{6, 16};
        run(0, 17, 100, 100, -1, -1, 1'b1);
        n_checks++; if (act_d.size() !== 13) $display("FAIL early_count got %0d want 13", act_d.size()); else n_pass++;
        for (int i = 0; i < act_d.size() && i < exp_d.size(); i++) begin
            n_checks++;
            if (act_d[i] !== exp_d[i] || act_l[i] !== exp_l[i])
                $display("FAIL early_out[%0d] got %h/%b want %h/%b", i, act_d[i], act_l[i], exp_d[i], exp_l[i]);
            else n_pass++;
        end
        if (act_d.size() >= 6) begin
            n_checks++; if (act_d[4] !== 32'd6 || act_l[4] !== 1'b1) $display("FAIL early_close got %h/%b want 6/1", act_d[4], act_l[4]); else n_pass++;
            n_checks++; if (act_d[5] !== 32'd9) $display("FAIL early_resume got %h want 9", act_d[5]); else n_pass++;
        end
        n_checks++; if (sync_err !== exp_err) $display("FAIL early_sync_err got %b want %b", sync_err, exp_err); else n_pass++;
        n_checks++; if (sync_err !== 1'b1) $display("FAIL early_sync_err_set got %b want 1", sync_err); else n_pass++;
    endtask

    // Follows test_early_tlast without a reset so sync_err starts set.
    task automatic test_reset_mid();
        clear_model();
        in_last_k.delete();
        run(0, 6, 100, 100, -1, -1, 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++; if (m_tvalid !== 1'b0) $display("FAIL midrst_tvalid got %b want 0", m_tvalid); else n_pass++;
        n_checks++; if (m_tdata !== 32'h0) $display("FAIL midrst_tdata got %h want 0", m_tdata); else n_pass++;
        n_checks++; if (m_tlast !== 1'b0) $display("FAIL midrst_tlast got %b want 0", m_tlast); else n_pass++;
        n_checks++; if (sync_err !== 1'b0) $display("FAIL midrst_sync_err got %b want 0", sync_err); else n_pass++;
        n_checks++; if (s_tready !== 1'b1) $display("FAIL midrst_tready got %b want 1", s_tready); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_model();
        in_last_k = '{15};
        run(6, 10, 100, 100, -1, -1, 1'b1);
        n_checks++; if (act_d.size() !== 8) $display("FAIL midrst_count got %0d want 8", act_d.size()); else n_pass++;
        n_checks++; if (act_d.size() > 0 && act_d[0] !== 32'd8) $display("FAIL midrst_first got %h want 8", act_d[0]); else n_pass++;
        for (int i = 0; i < act_d.size() && i < exp_d.size(); i++) begin
            n_checks++;
            if (act_d[i] !== exp_d[i] || act_l[i] !== exp_l[i])
                $display("FAIL midrst_out[%0d] got %h/%b want %h/%b", i, act_d[i], act_l[i], exp_d[i], exp_l[i]);
            else n_pass++;
        end
        n_checks++; if (sync_err !== 1'b0) $display("FAIL midrst_sync_after got %b want 0", sync_err); else n_pass++;
    endtask

    initial begin
        s_tstrb  = 4'hF;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        rst_n    = 1'b0;
        test_reset();
        test_continuous();
        test_stall();
        test_random();
        test_early_tlast();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
